gpio_arbiter: RTL and testbench

GPIO_ARBITER -- requirements
Module: gpio_arbiter

---
 rtl/gpio_arbiter_if.sv | 41 ++++
 rtl/gpio_arbiter.sv | 110 +++++++++++
 tb/tb_gpio_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_arbiter_if.sv
// Bundle of the two requester ports and the GPIO register port seen by gpio_arbiter.
interface gpio_arbiter_if;
    logic        req0_valid;
    logic        req0_we;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        req0_rvalid;
    logic [31:0] req0_rdata;

    logic        req1_valid;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        req1_rvalid;
    logic [31:0] req1_rdata;

    logic        gpio_wr_en;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_wr_data;
    logic [31:0] gpio_rd_data;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output gpio_wr_en, gpio_addr, gpio_wr_data,
        input  gpio_rd_data
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  gpio_wr_en, gpio_addr, gpio_wr_data,
        output gpio_rd_data
    );
endinterface

// File: rtl/gpio_arbiter.sv
// Two-requester arbiter onto one GPIO register port, IDLE -> ISSUE -> RESP per transaction.
// Define GPIO_ARB_FIXED_PRIO_EN for strict requester-0 priority instead of burst-limited round-robin.
module gpio_arbiter #(
    parameter int BURST_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    gpio_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic [3:0]      burst_cnt, burst_cnt_nxt;
    req_t            cur;
    req_t [1:0]      req;
    logic [1:0]      valid;
    logic [1:0]      ready;
    logic [1:0][31:0] rdata;
    logic            win;
    logic            accept;

    assign valid  = {bus.req1_valid, bus.req0_valid};
    assign req[0] = {bus.req0_we, bus.req0_addr, bus.req0_wdata};
    assign req[1] = {bus.req1_we, bus.req1_addr, bus.req1_wdata};

    always_comb begin
        win = 1'b0;
        if (valid == 2'b10) begin
            win = 1'b1;
        end else if (valid == 2'b11) begin
`ifdef GPIO_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            // burst_cnt is 0 only before the first grant after reset; that tie goes to requester 0
            if (burst_cnt == 4'd0)
                win = ~owner;
            else if (burst_cnt < BMAX)
                win = owner;
            else
                win = ~owner;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        ready         = 2'b00;
        accept        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && valid != 2'b00) begin
                    ready[win] = 1'b1;
                    accept     = 1'b1;
                    state_nxt  = ISSUE;
                    owner_nxt  = win;
                    if (win == owner)
                        burst_cnt_nxt = (burst_cnt < BMAX) ? burst_cnt + 4'd1 : burst_cnt;
                    else
                        burst_cnt_nxt = 4'd1;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b1;
            burst_cnt <= 4'd0;
            cur       <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (accept)
                cur <= req[win];
            // owner still names the requester being served until the next acceptance
            if (state == ISSUE)
                rdata[owner] <= cur.we ? 32'h0 : bus.gpio_rd_data;
        end
    end

    assign bus.req0_ready   = ready[0];
    assign bus.req1_ready   = ready[1];
    assign bus.req0_rvalid  = (state == RESP) && !owner;
    assign bus.req1_rvalid  = (state == RESP) && owner;
    assign bus.req0_rdata   = rdata[0];
    assign bus.req1_rdata   = rdata[1];
    assign bus.gpio_wr_en   = (state == ISSUE) && cur.we;
    assign bus.gpio_addr    = cur.addr;
    assign bus.gpio_wr_data = cur.wdata;

    a_one_ready: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
    a_ready_idle: assert property (@(posedge clk) (bus.req0_ready || bus.req1_ready) |-> (state == IDLE));
endmodule

// File: tb/tb_gpio_arbiter.sv
// Scoreboard bench for gpio_arbiter: random and directed stimulus, rule-level reference model.
module tb_gpio_arbiter;
    localparam int BMAX = 4;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] rdata;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    gpio_arbiter_if bus();
    gpio_arbiter #(.BURST_MAX(BMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file stand-in: read data is a fixed scramble of the address (0 -> 0x5A)
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_005A;
    endfunction
    assign bus.gpio_rd_data = rd_fn(bus.gpio_addr);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    gexp_t gq[$];
    rexp_t rq[$];

    // reference model state: last winner (-1 = none since reset), its run length, busy cycles left
    int m_last = -1;
    int m_run  = 0;
    int m_wait = 0;

    function automatic int pick(input logic v0, input logic v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef GPIO_ARB_FIXED_PRIO_EN
        return 0;
`else
        if (m_last < 0) return 0;
        return (m_run < BMAX) ? m_last : 1 - m_last;
`endif
    endfunction

    always @(negedge clk) begin : model
        logic [1:0] er;
        int w;
        er = 2'b00;
        w  = -1;
        if (!rst && m_wait == 0 && (bus.req0_valid || bus.req1_valid)) begin
            w = pick(bus.req0_valid, bus.req1_valid);
            er[w] = 1'b1;
        end
        check("ready", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, er});
        if (rst) begin
            m_last = -1;
            m_run  = 0;
            m_wait = 0;
        end else if (w >= 0) begin
            m_run  = (w == m_last) ? ((m_run < BMAX) ? m_run + 1 : m_run) : 1;
            m_last = w;
            m_wait = 2;
            if (w == 0) begin
                gq.push_back('{cyc + 1, bus.req0_we, bus.req0_addr, bus.req0_wdata});
                rq.push_back('{cyc + 2, 0, bus.req0_we ? 32'h0 : rd_fn(bus.req0_addr)});
            end else begin
                gq.push_back('{cyc + 1, bus.req1_we, bus.req1_addr, bus.req1_wdata});
                rq.push_back('{cyc + 2, 1, bus.req1_we ? 32'h0 : rd_fn(bus.req1_addr)});
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end
    end

    logic [31:0]      last_addr  = '0;
    logic [31:0]      last_wdata = '0;
    logic [1:0][31:0] hold       = '0;

    always @(negedge clk) begin : monitor
        gexp_t g;
        rexp_t r;
        int    n;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            check("issue_overdue", 32'(cyc), 32'(gq[0].cyc));
            void'(gq.pop_front());
        end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("gpio_wr_en", 32'(bus.gpio_wr_en), 32'(g.we));
            check("gpio_addr", bus.gpio_addr, g.addr);
            check("gpio_wr_data", bus.gpio_wr_data, g.wdata);
            last_addr  = g.addr;
            last_wdata = g.wdata;
        end else begin
            check("gpio_wr_en_idle", 32'(bus.gpio_wr_en), 32'd0);
            check("gpio_addr_hold", bus.gpio_addr, last_addr);
            check("gpio_wr_data_hold", bus.gpio_wr_data, last_wdata);
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            check("rvalid_overdue", 32'(cyc), 32'(rq[0].cyc));
            void'(rq.pop_front());
        end
        if (bus.req0_rvalid || bus.req1_rvalid) begin
            n = bus.req1_rvalid ? 1 : 0;
            check("rvalid_exclusive", 32'(bus.req0_rvalid & bus.req1_rvalid), 32'd0);
            if (rq.size() == 0) begin
                check("rvalid_unexpected", 32'(bus.req0_rvalid | bus.req1_rvalid), 32'd0);
            end else begin
                r = rq.pop_front();
                check("rvalid_id", 32'(n), 32'(r.id));
                check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                hold[r.id] = r.rdata;
            end
        end
        check("req0_rdata", bus.req0_rdata, hold[0]);
        check("req1_rdata", bus.req1_rdata, hold[1]);
        if (rst) begin
            gq.delete();
            rq.delete();
            last_addr  = '0;
            last_wdata = '0;
            hold       = '0;
        end
    end

    task automatic set_req(input int n, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic set_rand(input int n, input logic v);
        set_req(n, v, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"},  32'(bus.req0_ready), 32'd0);
        check({tag, "_req1_ready"},  32'(bus.req1_ready), 32'd0);
        check({tag, "_req0_rvalid"}, 32'(bus.req0_rvalid), 32'd0);
        check({tag, "_req1_rvalid"}, 32'(bus.req1_rvalid), 32'd0);
        check({tag, "_req0_rdata"},  bus.req0_rdata, 32'd0);
        check({tag, "_req1_rdata"},  bus.req1_rdata, 32'd0);
        check({tag, "_gpio_wr_en"},  32'(bus.gpio_wr_en), 32'd0);
        check({tag, "_gpio_addr"},   bus.gpio_addr, 32'd0);
        check({tag, "_gpio_wr_data"}, bus.gpio_wr_data, 32'd0);
    endtask

    task automatic do_reset(input logic v0, input logic v1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int id);
        int t;
        id = -1;
        t  = 0;
        while (id < 0 && t < 40) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) id = 0;
            else if (bus.req1_valid && bus.req1_ready) id = 1;
            t++;
        end
        if (id < 0) check("grant_timeout", 32'(t), 32'd0);
    endtask

    task automatic send(input int n, input logic we, input logic [31:0] a, input logic [31:0] d);
        int id;
        set_req(n, 1'b1, we, a, d);
        wait_grant(id);
        check("send_grant", 32'(id), 32'(n));
        @(posedge clk); #1;
        set_req(n, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drive_rand(input int n, input logic acc, input int pct);
        logic v;
        v = (n == 0) ? bus.req0_valid : bus.req1_valid;
        if (v && !acc) begin
            if ($urandom_range(0, 99) < 8) set_rand(n, 1'b0);
        end else begin
            set_rand(n, 1'($urandom_range(0, 99) < pct));
        end
    endtask

    int exp_order [9];

    initial begin
        int id;
        logic a0, a1;
`ifdef GPIO_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset(1'b1, 1'b1);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // single write, then single read of address 0
        send(0, 1'b1, 32'h4, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        send(1, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // a one-cycle req1 pulse landing in RESP must be ignored
        send(0, 1'b1, 32'h10, 32'hCAFE_0001);
        @(posedge clk); #1;
        set_rand(1, 1'b1);
        @(negedge clk);
        check("resp_pulse_req1_ready", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // both requesters valid continuously from reset
        set_rand(0, 1'b1);
        set_rand(1, 1'b1);
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            wait_grant(id);
            check("burst_grant", 32'(id), 32'(exp_order[k]));
            @(posedge clk); #1;
            if (id >= 0) set_rand(id, 1'b1);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // reset during ISSUE of a read abandons it
        do_reset(1'b0, 1'b0);
        set_req(0, 1'b1, 1'b0, $urandom | 32'h1, 32'h0);
        wait_grant(id);
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");
        @(posedge clk); #1;
        set_rand(0, 1'b1);
        set_rand(1, 1'b1);
        wait_grant(id);
        check("first_tie_after_rst", 32'(id), 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // random traffic with withdrawals and field changes after acceptance
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid & bus.req0_ready;
            a1 = bus.req1_valid & bus.req1_ready;
            @(posedge clk); #1;
            drive_rand(0, a0, 60);
            drive_rand(1, a1, 50);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("issue_queue_drained", 32'(gq.size()), 32'd0);
        check("resp_queue_drained", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
